// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the MIPS pipeline.
// Drives PC hold/redirect and IF/ID, ID/EX stall/flush/bubble controls.
module pipe_hazard_ctrl #(
    parameter int PC_W     = 16,
    parameter int REG_W    = 5,
    parameter int LD_STALL = 1,
    parameter int MD_LAT   = 4
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             id_jmp_i,
    input  logic [PC_W-1:0]  id_jmp_tgt_i,
    input  logic             ex_memrd_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic             ex_md_start_i,
    input  logic             ex_br_taken_i,
    input  logic [PC_W-1:0]  ex_br_tgt_i,
    output logic             haz_o,
    output logic [PC_W-1:0]  cnt_jmp_o,
    output logic             if_id_stall_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             ex_hold_o,
    output logic             bad_tgt_o,
    output logic [1:0]       state_o
);

    localparam int MAX_L = (LD_STALL > MD_LAT) ? LD_STALL : MD_LAT;
    localparam int CNT_W = $clog2(MAX_L + 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LDUSE  = 2'd1,
        MDBUSY = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_nstate;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_ncnt;
    logic               w_ld_hit;

    logic               w_haz;
    logic               w_stall;
    logic               w_flush;
    logic               w_bubble;
    logic               w_hold;
    logic               w_redir;
    logic [PC_W-1:0]    w_tgt;

    // A zero destination never creates a dependency (r0 is hardwired)
    assign w_ld_hit = ex_memrd_i && (ex_rd_i != '0) &&
                      ((ex_rd_i == id_rs_i) ||
                       (id_uses_rt_i && (ex_rd_i == id_rt_i)));

    // State and stall counter register
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
        end
    end

    // Next state: a taken branch aborts any stall, else count down
    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        if (ex_br_taken_i) begin
            w_nstate = RUN;
            w_ncnt   = '0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (ex_md_start_i) begin
                        w_ncnt   = CNT_W'(MD_LAT - 1);
                        w_nstate = (MD_LAT > 1) ? MDBUSY : RUN;
                    end else if (w_ld_hit) begin
                        w_ncnt   = CNT_W'(LD_STALL - 1);
                        w_nstate = (LD_STALL > 1) ? LDUSE : RUN;
                    end
                end
                LDUSE, MDBUSY: begin
                    if (r_cnt == CNT_W'(1)) begin
                        w_nstate = RUN;
                        w_ncnt   = '0;
                    end else begin
                        w_ncnt = r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    w_nstate = RUN;
                    w_ncnt   = '0;
                end
            endcase
        end
    end

    // Output decode: branch > mul/div > load-use > jump
    always_comb begin
        w_haz    = 1'b0;
        w_stall  = 1'b0;
        w_flush  = 1'b0;
        w_bubble = 1'b0;
        w_hold   = 1'b0;
        w_redir  = 1'b0;
        w_tgt    = '0;
        if (ex_br_taken_i) begin
            w_redir  = 1'b1;
            w_tgt    = ex_br_tgt_i;
            w_flush  = 1'b1;
            w_bubble = 1'b1;
        end else if (r_state == MDBUSY ||
                     (r_state == RUN && ex_md_start_i)) begin
            w_haz   = 1'b1;
            w_stall = 1'b1;
            w_hold  = 1'b1;
        end else if (r_state == LDUSE ||
                     (r_state == RUN && w_ld_hit)) begin
            w_haz    = 1'b1;
            w_stall  = 1'b1;
            w_bubble = 1'b1;
        end else if (r_state == RUN && id_jmp_i) begin
            w_redir = 1'b1;
            w_tgt   = id_jmp_tgt_i;
            w_flush = 1'b1;
        end
    end

    // Reset blanks every output immediately, even mid-cycle
    always_comb begin
        haz_o          = rst_n & w_haz;
        cnt_jmp_o      = rst_n ? w_tgt : '0;
        if_id_stall_o  = rst_n & w_stall;
        if_id_flush_o  = rst_n & w_flush;
        id_ex_bubble_o = rst_n & w_bubble;
        ex_hold_o      = rst_n & w_hold;
        bad_tgt_o      = rst_n & w_redir & (w_tgt == '0);
        state_o        = rst_n ? r_state : 2'd0;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two parameterisations against a
// remaining-stall-cycles reference model, directed then random.
module tb_pipe_hazard_ctrl;

    localparam int PC_W  = 16;
    localparam int REG_W = 5;

    logic             clk_i = 1'b0;
    logic             rst_n;
    logic [REG_W-1:0] id_rs, id_rt, ex_rd;
    logic             id_uses_rt, id_jmp;
    logic             ex_memrd, ex_md, ex_br;
    logic [PC_W-1:0]  id_tgt, br_tgt;

    logic [1:0]            o_haz, o_stall, o_flush;
    logic [1:0]            o_bub, o_hold, o_bad;
    logic [1:0][PC_W-1:0]  o_jmp;
    logic [1:0][1:0]       o_st;

    int n_err = 0;
    int n_chk = 0;
    int rem [2];
    int kind [2];

    always #5 clk_i = ~clk_i;

    pipe_hazard_ctrl u_dut0 (
        .clk_i(clk_i), .rst_n(rst_n),
        .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_uses_rt_i(id_uses_rt), .id_jmp_i(id_jmp),
        .id_jmp_tgt_i(id_tgt), .ex_memrd_i(ex_memrd),
        .ex_rd_i(ex_rd), .ex_md_start_i(ex_md),
        .ex_br_taken_i(ex_br), .ex_br_tgt_i(br_tgt),
        .haz_o(o_haz[0]), .cnt_jmp_o(o_jmp[0]),
        .if_id_stall_o(o_stall[0]), .if_id_flush_o(o_flush[0]),
        .id_ex_bubble_o(o_bub[0]), .ex_hold_o(o_hold[0]),
        .bad_tgt_o(o_bad[0]), .state_o(o_st[0])
    );

    pipe_hazard_ctrl #(.LD_STALL(3), .MD_LAT(1)) u_dut1 (
        .clk_i(clk_i), .rst_n(rst_n),
        .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_uses_rt_i(id_uses_rt), .id_jmp_i(id_jmp),
        .id_jmp_tgt_i(id_tgt), .ex_memrd_i(ex_memrd),
        .ex_rd_i(ex_rd), .ex_md_start_i(ex_md),
        .ex_br_taken_i(ex_br), .ex_br_tgt_i(br_tgt),
        .haz_o(o_haz[1]), .cnt_jmp_o(o_jmp[1]),
        .if_id_stall_o(o_stall[1]), .if_id_flush_o(o_flush[1]),
        .id_ex_bubble_o(o_bub[1]), .ex_hold_o(o_hold[1]),
        .bad_tgt_o(o_bad[1]), .state_o(o_st[1])
    );

    // Load and mul/div together is an illegal stimulus combination
    always @(posedge clk_i) begin
        if (rst_n) begin
            assert (!(ex_memrd && ex_md))
            else $error("illegal memrd+md stimulus");
        end
    end

    function automatic int ld_len(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int md_len(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic logic hit();
        return ex_memrd && ex_rd != 0 &&
               (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h want %0h",
                     tag, $time, got, exp);
        end
    endtask

    // Expected outputs from the model, compared per instance
    task automatic cmp_all();
        for (int k = 0; k < 2; k++) begin
            logic e_haz, e_stl, e_fl, e_bub, e_hold, e_bad;
            logic [PC_W-1:0] e_jmp;
            logic [1:0] e_st;
            e_haz = 0; e_stl = 0; e_fl = 0; e_bub = 0;
            e_hold = 0; e_bad = 0; e_jmp = '0; e_st = 0;
            if (rst_n) begin
                e_st = (rem[k] > 0) ? 2'(kind[k]) : 2'd0;
                if (ex_br) begin
                    e_jmp = br_tgt; e_fl = 1; e_bub = 1;
                    e_bad = (br_tgt == 0);
                end else if ((rem[k] > 0 && kind[k] == 2) ||
                             (rem[k] == 0 && ex_md)) begin
                    e_haz = 1; e_stl = 1; e_hold = 1;
                end else if (rem[k] > 0 || hit()) begin
                    e_haz = 1; e_stl = 1; e_bub = 1;
                end else if (id_jmp) begin
                    e_jmp = id_tgt; e_fl = 1;
                    e_bad = (id_tgt == 0);
                end
            end
            chk($sformatf("u%0d.haz", k), 32'(o_haz[k]), 32'(e_haz));
            chk($sformatf("u%0d.jmp", k), 32'(o_jmp[k]), 32'(e_jmp));
            chk($sformatf("u%0d.stall", k), 32'(o_stall[k]), 32'(e_stl));
            chk($sformatf("u%0d.flush", k), 32'(o_flush[k]), 32'(e_fl));
            chk($sformatf("u%0d.bubble", k), 32'(o_bub[k]), 32'(e_bub));
            chk($sformatf("u%0d.hold", k), 32'(o_hold[k]), 32'(e_hold));
            chk($sformatf("u%0d.bad", k), 32'(o_bad[k]), 32'(e_bad));
            chk($sformatf("u%0d.state", k), 32'(o_st[k]), 32'(e_st));
        end
    endtask

    // Model advance: rem = stall cycles still to come after this one
    task automatic upd();
        for (int k = 0; k < 2; k++) begin
            if (!rst_n || ex_br) rem[k] = 0;
            else if (rem[k] > 0) rem[k]--;
            else if (ex_md) begin
                rem[k] = md_len(k) - 1; kind[k] = 2;
            end else if (hit()) begin
                rem[k] = ld_len(k) - 1; kind[k] = 1;
            end
        end
    endtask

    task automatic settle();
        #1;
        cmp_all();
    endtask

    task automatic adv();
        @(posedge clk_i);
        upd();
        @(negedge clk_i);
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; ex_rd = 0; id_uses_rt = 0;
        id_jmp = 0; id_tgt = 0; ex_memrd = 0; ex_md = 0;
        ex_br = 0; br_tgt = 0;
    endtask

    task automatic idle_n(input int n);
        idle();
        for (int i = 0; i < n; i++) begin
            settle(); adv();
        end
    endtask

    initial begin
        logic [1:0] st_seq [5];
        st_seq = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd0};
        rem = '{0, 0};
        kind = '{0, 0};
        idle();
        rst_n = 0;
        repeat (2) @(negedge clk_i);
        upd();
        rst_n = 1;
        settle();
        chk("rst_idle_haz", 32'(o_haz[0]), 0);
        chk("rst_idle_state", 32'(o_st[0]), 0);
        adv();

        // load-use hit, then r0 destination
        ex_memrd = 1; ex_rd = 5; id_rs = 5;
        settle();
        chk("ld_haz", 32'(o_haz[0]), 1);
        chk("ld_bubble", 32'(o_bub[0]), 1);
        chk("ld_state", 32'(o_st[0]), 0);
        adv();
        idle(); settle();
        chk("ld_len", 32'(o_haz[0]), 0);
        adv();
        idle_n(3);
        ex_memrd = 1; ex_rd = 0; id_rs = 0;
        settle();
        chk("ld_r0", 32'(o_haz[0]), 0);
        adv();
        idle_n(2);

        // mul/div occupancy
        ex_md = 1;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk($sformatf("md_st%0d", i), 32'(o_st[0]), 32'(st_seq[i]));
            chk($sformatf("md_hold%0d", i), 32'(o_hold[0]),
                (i < 4) ? 1 : 0);
            adv();
            idle();
        end
        idle_n(2);

        // branch aborts MDBUSY
        ex_md = 1; settle(); adv();
        idle(); settle(); adv();
        ex_br = 1; br_tgt = 16'h0040;
        settle();
        chk("br_tgt", 32'(o_jmp[0]), 32'h40);
        chk("br_flush", 32'(o_flush[0]), 1);
        chk("br_bubble", 32'(o_bub[0]), 1);
        adv();
        idle(); settle();
        chk("br_after_st", 32'(o_st[0]), 0);
        chk("br_after_haz", 32'(o_haz[0]), 0);
        adv();
        idle_n(2);

        // jump loses to load-use, then redirects
        id_jmp = 1; id_tgt = 16'h0100;
        ex_memrd = 1; ex_rd = 5; id_rs = 5;
        settle();
        chk("pri_haz", 32'(o_haz[0]), 1);
        chk("pri_jmp", 32'(o_jmp[0]), 0);
        adv();
        ex_memrd = 0; ex_rd = 0;
        settle();
        chk("pri_redir", 32'(o_jmp[0]), 32'h100);
        chk("pri_flush", 32'(o_flush[0]), 1);
        adv();
        idle_n(3);

        // zero branch target
        ex_br = 1; br_tgt = 0;
        settle();
        chk("z_jmp", 32'(o_jmp[0]), 0);
        chk("z_flush", 32'(o_flush[0]), 1);
        chk("z_bad", 32'(o_bad[0]), 1);
        adv();
        idle(); settle();
        chk("z_bad_off", 32'(o_bad[0]), 0);
        adv();

        // async reset while MDBUSY with cnt=2
        ex_md = 1; settle(); adv();
        idle(); settle(); adv();
        settle();
        chk("pre_rst_st", 32'(o_st[0]), 2);
        #1 rst_n = 0;
        settle();
        chk("rst_st", 32'(o_st[0]), 0);
        chk("rst_haz", 32'(o_haz[0]), 0);
        chk("rst_hold", 32'(o_hold[0]), 0);
        adv();
        rst_n = 1;
        settle();
        chk("rel_haz", 32'(o_haz[0]), 0);
        chk("rel_st", 32'(o_st[0]), 0);
        adv();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            ex_br = ($urandom_range(0, 9) == 0);
            ex_md = ($urandom_range(0, 11) == 0);
            ex_memrd = !ex_md && ($urandom_range(0, 2) == 0);
            ex_rd = REG_W'($urandom_range(0, 3));
            id_rs = REG_W'($urandom_range(0, 3));
            id_rt = REG_W'($urandom_range(0, 3));
            id_uses_rt = 1'($urandom_range(0, 1));
            id_jmp = ($urandom_range(0, 3) == 0);
            id_tgt = ($urandom_range(0, 7) == 0) ? '0 : PC_W'($urandom);
            br_tgt = ($urandom_range(0, 7) == 0) ? '0 : PC_W'($urandom);
            settle();
            adv();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
